button_conditioner: RTL

Input-conditioning stage directly upstream of the multiplier processor. It turns raw, bouncing, active-low board pushbuttons and raw slide switches into clean signals for the processor and its control FSM. Outputs are synchronized, debounced, active-high levels, plus single-cycle press and release pulses. The processor consumes the pulses (Run, ClearA_LoadB) and the synchronized switch byte (operand S) without further synchronization.

---
 rtl/mult_io_pkg.sv | 20 ++
 rtl/button_conditioner_debounce_bit.sv | 94 +++++++++
 rtl/button_conditioner.sv | 55 +++++
 3 files changed

// File: rtl/mult_io_pkg.sv
// Shared definitions for the multiplier I/O conditioning stage.
// Holds the button channel names used by the processor wiring,
// the short debounce length for simulation, and the per-button
// debounce state encoding.
package mult_io_pkg;

  // Button channel indices. The processor refers to buttons by these names.
  localparam int BTN_RUN   = 2;
  localparam int BTN_CLRLD = 1;
  localparam int BTN_AUX   = 0;

  // Short debounce length so simulations stay small.
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  typedef enum logic {
    ST_STABLE  = 1'b0,  // synced sample matches the accepted level
    ST_PENDING = 1'b1   // sample differs; counting stable cycles
  } db_state_e;

endpackage

// File: rtl/button_conditioner_debounce_bit.sv
// debounce_bit: one pushbutton channel.
// Two-flop synchronizer on the inverted (active-high) button, a stable-cycle
// counter, the accepted level and registered press/release pulses.
// Ports:
//   clk, reset  - clock, async active-high reset
//   btn_n_i     - raw active-low button, asynchronous to clk
//   level_o     - debounced level, 1 = pressed
//   press_o     - one-cycle pulse when level_o goes 0 -> 1
//   release_o   - one-cycle pulse when level_o goes 1 -> 0
module debounce_bit
  import mult_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sample;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          mismatch, accept;

  assign sample   = sync_q[1];
  assign mismatch = (sample != lvl_q);

  // A change is accepted on the cycle the count would reach DEBOUNCE_CYCLES.
  // Entering PENDING already counts the first mismatching cycle, so the
  // counter is loaded with 1 on entry; with a length of 1 the change is
  // accepted straight from STABLE.
  assign accept = mismatch &&
                  ((state_q == ST_PENDING) ? (cnt_q == CNT_LAST) : (CNT_LAST == '0));

  // State register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], ~btn_n_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STABLE:  if (mismatch && !accept) state_d = ST_PENDING;
      ST_PENDING: if (!mismatch || accept) state_d = ST_STABLE;
      default:    state_d = ST_STABLE;
    endcase
  end

  // Counter, level and pulse next values. The counter is cleared on any
  // bounce or on acceptance, so it never wraps.
  always_comb begin
    cnt_d   = '0;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (accept) begin
      lvl_d   = sample;
      press_d = sample;
      rel_d   = ~sample;
    end else if (mismatch) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level_o   = lvl_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: conditions raw board pushbuttons and slide switches
// for the multiplier processor.
// Ports:
//   clk, reset  - clock, async active-high reset
//   btn_n       - raw active-low pushbuttons [N_BTN]
//   sw          - raw slide switches [SW_W]
//   btn_level   - debounced active-high button levels
//   btn_press   - one-cycle press pulses
//   btn_release - one-cycle release pulses
//   sw_s        - two-flop synchronized switches (no debounce)
module button_conditioner
  import mult_io_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int SW_W            = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  input  logic [SW_W-1:0]  sw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [SW_W-1:0]  sw_s
);

  logic [SW_W-1:0] sw_meta_q, sw_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign sw_s = sw_sync_q;

  for (genvar i = 0; i < N_BTN; i++) begin : gen_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk       (clk),
      .reset     (reset),
      .btn_n_i   (btn_n[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i])
    );
  end

endmodule
